// File: rtl/bullet_red_ctl.sv
// bullet_red_ctl: spawns, advances and retires the red tank's bullet once per frame tick
module bullet_red_ctl #(
  parameter int SCREEN_W      = 800,
  parameter int SCREEN_H      = 600,
  parameter int SPEED         = 4,
  parameter int TANK_W        = 64,
  parameter int BULLET_SIZE   = 4,
  parameter int RELOAD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       fire,
  input  logic [9:0] xpos_tank_red,
  input  logic [9:0] ypos_tank_red,
  input  logic [1:0] dir_red,
  input  logic [9:0] xpos_tank_our,
  input  logic [9:0] ypos_tank_our,
  output logic [9:0] xpos_bullet_red,
  output logic [9:0] ypos_bullet_red,
  output logic       tank_enemy_hit_us,
  output logic       busy
);
  localparam int CW = $clog2(RELOAD_FRAMES + 2);
  localparam logic [CW-1:0] RL = CW'(RELOAD_FRAMES == 0 ? 1 : RELOAD_FRAMES);
  localparam logic [9:0] OFF = 10'(TANK_W / 2 - BULLET_SIZE / 2);
  localparam logic signed [10:0] SP = 11'(SPEED);
  localparam logic signed [10:0] XMAX = 11'(SCREEN_W - BULLET_SIZE);
  localparam logic signed [10:0] YMAX = 11'(SCREEN_H - BULLET_SIZE);
  localparam logic [11:0] BS = 12'(BULLET_SIZE);
  localparam logic [11:0] TW = 12'(TANK_W);
  typedef enum logic [1:0] {IDLE = 2'd0, FLY = 2'd1, RELOAD = 2'd2} state_t;
  state_t state_q, state_d;
  logic vblnk_q, tick, hit_q, hit_d, out, ovl;
  logic [1:0] dir_q, dir_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [10:0] sx, sy, nx, ny;
  logic [11:0] nxe, nye, xt, yt;
  assign tick = vblnk & ~vblnk_q;
  assign sx = $signed({1'b0, x_q});
  assign sy = $signed({1'b0, y_q});
  assign nx = dir_q == 2'b01 ? sx + SP : dir_q == 2'b11 ? sx - SP : sx;
  assign ny = dir_q == 2'b10 ? sy + SP : dir_q == 2'b00 ? sy - SP : sy;
  assign out = nx[10] | ny[10] | (nx > XMAX) | (ny > YMAX);
  // overlap is only meaningful for in-bounds (non-negative) positions; out takes priority
  assign nxe = {1'b0, nx};
  assign nye = {1'b0, ny};
  assign xt = {2'b00, xpos_tank_our};
  assign yt = {2'b00, ypos_tank_our};
  assign ovl = (nxe + BS > xt) && (nxe < xt + TW) && (nye + BS > yt) && (nye < yt + TW);
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    case (state_q)
      IDLE: begin
        x_d   = fire ? xpos_tank_red + OFF : 10'd0;
        y_d   = fire ? ypos_tank_red + OFF : 10'd0;
        dir_d = fire ? dir_red : dir_q;
        cnt_d = '0;
        state_d = fire ? FLY : IDLE;
      end
      FLY: if (tick) begin
        x_d     = (out | ovl) ? 10'd0 : nx[9:0];
        y_d     = (out | ovl) ? 10'd0 : ny[9:0];
        cnt_d   = (out | ovl) ? RL : cnt_q;
        hit_d   = ~out & ovl;
        state_d = (out | ovl) ? RELOAD : FLY;
      end
      RELOAD: if (tick) begin
        cnt_d   = cnt_q <= 1 ? '0 : cnt_q - 1'b1;
        state_d = cnt_q <= 1 ? IDLE : RELOAD;
      end
      default: begin
        state_d = IDLE;
        x_d     = 10'd0;
        y_d     = 10'd0;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vblnk_q <= 1'b0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      dir_q   <= 2'b00;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vblnk_q <= vblnk;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
    end
  end
  assign xpos_bullet_red   = x_q;
  assign ypos_bullet_red   = y_q;
  assign tank_enemy_hit_us = hit_q;
  assign busy              = state_q == FLY || state_q == RELOAD;
endmodule

// File: tb/tb_bullet_red_ctl.sv
// tb_bullet_red_ctl: vector table through a scoreboard queue plus hand sequences for reload, hit pulse and async reset
module tb_bullet_red_ctl;
  logic clk = 1'b0, rst = 1'b0, vblnk = 1'b0, fire = 1'b0;
  logic [9:0] xpos_tank_red = '0, ypos_tank_red = '0, xpos_tank_our = '0, ypos_tank_our = '0;
  logic [1:0] dir_red = '0;
  logic [9:0] xpos_bullet_red, ypos_bullet_red;
  logic tank_enemy_hit_us, busy;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    int rx, ry, dir, ox, oy, ticks, spx, spy, ex, ey, eb, eh;
  } vec_t;
  vec_t vecs[9];
  vec_t sb[$];

  bullet_red_ctl dut (
    .clk(clk), .rst(rst), .vblnk(vblnk), .fire(fire),
    .xpos_tank_red(xpos_tank_red), .ypos_tank_red(ypos_tank_red), .dir_red(dir_red),
    .xpos_tank_our(xpos_tank_our), .ypos_tank_our(ypos_tank_our),
    .xpos_bullet_red(xpos_bullet_red), .ypos_bullet_red(ypos_bullet_red),
    .tank_enemy_hit_us(tank_enemy_hit_us), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int rx, int ry, int dir, int ox, int oy, int t,
                              int spx, int spy, int ex, int ey, int eb, int eh);
    vec_t v;
    v.rx = rx; v.ry = ry; v.dir = dir; v.ox = ox; v.oy = oy; v.ticks = t;
    v.spx = spx; v.spy = spy; v.ex = ex; v.ey = ey; v.eb = eb; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; fire = 1'b0; vblnk = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_fire(input int rx, input int ry, input int dir);
    xpos_tank_red = 10'(rx); ypos_tank_red = 10'(ry); dir_red = 2'(dir);
    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
  endtask

  task automatic do_tick(output logic hit);
    vblnk = 1'b1;
    @(negedge clk);
    hit = tank_enemy_hit_us;
    vblnk = 1'b0;
    @(negedge clk);
    hit = hit | tank_enemy_hit_us;
  endtask

  task automatic ticks(input int n, inout logic hit);
    logic h;
    for (int k = 0; k < n; k++) begin
      do_tick(h);
      hit = hit | h;
    end
  endtask

  initial begin
    vec_t v, e;
    logic hit;
    vecs[0] = mk(100, 100, 1, 600, 500, 3, 130, 130, 142, 130, 1, 0);
    vecs[1] = mk(200,   0, 0, 600, 500, 7, 230,  30, 230,   2, 1, 0);
    vecs[2] = mk(200,   0, 0, 600, 500, 8, 230,  30,   0,   0, 1, 0);
    vecs[3] = mk(  0, 300, 1, 100, 290, 16, 30, 330,  94, 330, 1, 0);
    vecs[4] = mk(  0, 300, 1, 100, 290, 17, 30, 330,   0,   0, 1, 1);
    vecs[5] = mk(740, 100, 1, 799, 100, 6, 770, 130, 794, 130, 1, 0);
    vecs[6] = mk(740, 100, 1, 799, 100, 7, 770, 130,   0,   0, 1, 0);
    vecs[7] = mk(300, 200, 2,   0,   0, 5, 330, 230, 330, 250, 1, 0);
    vecs[8] = mk(300, 200, 3,   0,   0, 5, 330, 230, 310, 230, 1, 0);

    @(negedge clk);
    chk("rst_x", 32'(xpos_bullet_red), 0);
    chk("rst_y", 32'(ypos_bullet_red), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hit", 32'(tank_enemy_hit_us), 0);

    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      sb.push_back(v);
      do_reset();
      xpos_tank_our = 10'(v.ox); ypos_tank_our = 10'(v.oy);
      do_fire(v.rx, v.ry, v.dir);
      e = sb.pop_front();
      chk($sformatf("v%0d_spawn_x", i), 32'(xpos_bullet_red), e.spx);
      chk($sformatf("v%0d_spawn_y", i), 32'(ypos_bullet_red), e.spy);
      hit = 1'b0;
      ticks(v.ticks, hit);
      chk($sformatf("v%0d_x", i), 32'(xpos_bullet_red), e.ex);
      chk($sformatf("v%0d_y", i), 32'(ypos_bullet_red), e.ey);
      chk($sformatf("v%0d_busy", i), 32'(busy), e.eb);
      chk($sformatf("v%0d_hit", i), 32'(hit), e.eh);
    end

    // hit pulse lasts one clock and coincides with the position clearing
    do_reset();
    xpos_tank_our = 10'd100; ypos_tank_our = 10'd290;
    do_fire(0, 300, 1);
    hit = 1'b0;
    ticks(16, hit);
    vblnk = 1'b1;
    @(negedge clk);
    chk("pulse_hi", 32'(tank_enemy_hit_us), 1);
    chk("pulse_x", 32'(xpos_bullet_red), 0);
    chk("pulse_y", 32'(ypos_bullet_red), 0);
    vblnk = 1'b0;
    @(negedge clk);
    chk("pulse_lo", 32'(tank_enemy_hit_us), 0);
    chk("pulse_busy", 32'(busy), 1);

    // held fire and direction change during flight, then reload length and re-fire
    do_reset();
    xpos_tank_our = 10'd600; ypos_tank_our = 10'd500;
    xpos_tank_red = 10'd200; ypos_tank_red = 10'd0; dir_red = 2'b00;
    fire = 1'b1;
    @(negedge clk);
    chk("hold_spawn_y", 32'(ypos_bullet_red), 30);
    dir_red = 2'b01; xpos_tank_red = 10'd500;
    hit = 1'b0;
    ticks(7, hit);
    chk("hold_x", 32'(xpos_bullet_red), 230);
    chk("hold_y", 32'(ypos_bullet_red), 2);
    ticks(1, hit);
    chk("hold_out_x", 32'(xpos_bullet_red), 0);
    chk("hold_out_busy", 32'(busy), 1);
    chk("hold_out_hit", 32'(hit), 0);
    ticks(59, hit);
    chk("reload59_busy", 32'(busy), 1);
    chk("reload59_x", 32'(xpos_bullet_red), 0);
    vblnk = 1'b1;
    @(negedge clk);
    chk("reload60_busy", 32'(busy), 0);
    vblnk = 1'b0;
    @(negedge clk);
    chk("refire_busy", 32'(busy), 1);
    chk("refire_x", 32'(xpos_bullet_red), 530);
    chk("refire_y", 32'(ypos_bullet_red), 30);
    fire = 1'b0;

    // asynchronous reset in flight
    do_reset();
    xpos_tank_our = 10'd600; ypos_tank_our = 10'd500;
    do_fire(100, 100, 1);
    hit = 1'b0;
    ticks(2, hit);
    chk("pre_arst_x", 32'(xpos_bullet_red), 138);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_x", 32'(xpos_bullet_red), 0);
    chk("arst_y", 32'(ypos_bullet_red), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_hit", 32'(tank_enemy_hit_us), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ticks(3, hit);
    chk("post_arst_x", 32'(xpos_bullet_red), 0);
    chk("post_arst_busy", 32'(busy), 0);
    do_fire(100, 100, 1);
    chk("post_arst_fire_x", 32'(xpos_bullet_red), 130);
    chk("post_arst_fire_busy", 32'(busy), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
